if_id_buffer: RTL and testbench

- Pipeline buffer between the instruction fetch stage and the decode stage.
- Captures the 24-bit fetch bundle ({instr[15:0], pc[7:0]}) into a small FIFO and presents the head entry to decode under a valid/ready handshake.
- Pre-splits the instruction fields and back-pressures fetch when full.
- Flushes its contents on a taken branch so that wrong-path instructions never reach decode.

---
 rtl/if_id_buffer.sv | 105 ++++++++++
 tb/tb_if_id_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// Purpose : fetch->decode pipeline buffer; small FIFO of {instr, pc} bundles with pre-split decode fields.
// Latency : a bundle pushed into an empty buffer is visible on id_* right after the capturing edge.
// Backpr. : if_ready drops when all DEPTH entries are held; it depends on registered state only.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   if_in, if_valid     fetch bundle ([PC_W-1:0]=pc, upper INSTR_W bits=instr) and its valid
//   if_ready            buffer can take a bundle this cycle
//   flush               taken branch: drop all held entries and the incoming bundle
//   id_valid, id_ready  head-entry handshake towards decode
//   id_pc, id_instr     head entry; id_opcode/rd/rs1/rs2 are fixed slices of id_instr
//   occupancy           entries currently held
//   stall_cnt           saturating count of cycles where fetch was back-pressured
module if_id_buffer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PC_W+INSTR_W-1:0]    if_in,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic                       flush,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [PC_W-1:0]            id_pc,
    output logic [INSTR_W-1:0]         id_instr,
    output logic [3:0]                 id_opcode,
    output logic [3:0]                 id_rd,
    output logic [3:0]                 id_rs1,
    output logic [3:0]                 id_rs2,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [7:0]                 stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = PC_W + INSTR_W;
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [7:0]    stall_q, stall_d;
    logic [BW-1:0] head;
    logic          push, pop, stall;

    // Full/empty come from the occupancy counter, never from pointer equality.
    assign if_ready = (occ_q < FULL_C);
    assign id_valid = (occ_q != '0);

    assign push  = if_valid & if_ready & ~flush;
    assign pop   = id_valid & id_ready & ~flush;
    assign stall = if_valid & ~if_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        stall_d  = stall_q;
        if (flush) begin
            // Storage is left intact; only the bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps naturally, DEPTH is a power of two
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
        if (stall && (stall_q != 8'hFF)) stall_d = stall_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
            if (push) mem_q[wr_ptr_q] <= if_in;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign id_pc     = head[PC_W-1:0];
    assign id_instr  = head[BW-1:PC_W];
    assign id_opcode = id_instr[15:12];
    assign id_rd     = id_instr[11:8];
    assign id_rs1    = id_instr[7:4];
    assign id_rs2    = id_instr[3:0];
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    logic        clk;
    logic        rst_n;
    logic [23:0] if_in;
    logic        if_valid;
    logic        if_ready;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_pc;
    logic [15:0] id_instr;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rd;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic [1:0]  occupancy;
    logic [7:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    if_id_buffer #(.PC_W(8), .INSTR_W(16), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_in     (if_in),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_opcode (id_opcode),
        .id_rd     (id_rd),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_in    = '0;
        if_valid = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        #2;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_id_pc", 32'(id_pc), 32'd0);
        check("rst_id_instr", 32'(id_instr), 32'd0);
        #10;
        rst_n = 1'b1;

        // Single push into empty buffer
        if_valid = 1'b1; if_in = 24'h00F001; id_ready = 1'b1;
        tick();
        check("single_valid", 32'(id_valid), 32'd1);
        check("single_pc", 32'(id_pc), 32'h01);
        check("single_instr", 32'(id_instr), 32'h00F0);
        check("single_opcode", 32'(id_opcode), 32'h0);
        check("single_rd", 32'(id_rd), 32'h0);
        check("single_rs1", 32'(id_rs1), 32'hF);
        check("single_rs2", 32'(id_rs2), 32'h0);
        check("single_occ", 32'(occupancy), 32'd1);
        if_valid = 1'b0;
        tick();
        check("single_drain_valid", 32'(id_valid), 32'd0);
        check("single_drain_occ", 32'(occupancy), 32'd0);

        // Fill with decode stalled; third bundle must be rejected
        id_ready = 1'b0; if_valid = 1'b1; if_in = {16'h1234, 8'h00};
        tick();
        check("fill1_occ", 32'(occupancy), 32'd1);
        check("fill1_ready", 32'(if_ready), 32'd1);
        if_in = {16'h2345, 8'h01};
        tick();
        check("fill2_occ", 32'(occupancy), 32'd2);
        check("fill2_ready", 32'(if_ready), 32'd0);
        check("fill2_head", 32'(id_pc), 32'h00);
        if_in = {16'h3456, 8'h02};
        tick();
        check("fill3_occ", 32'(occupancy), 32'd2);
        check("fill3_stall", 32'(stall_cnt), 32'd1);
        check("fill3_head_stable", 32'(id_pc), 32'h00);
        check("fill3_instr_stable", 32'(id_instr), 32'h1234);
        if_valid = 1'b0; id_ready = 1'b1;
        tick();
        check("drain1_pc", 32'(id_pc), 32'h01);
        check("drain1_instr", 32'(id_instr), 32'h2345);
        check("drain1_occ", 32'(occupancy), 32'd1);
        tick();
        check("drain2_valid", 32'(id_valid), 32'd0);
        check("drain2_stall", 32'(stall_cnt), 32'd1);

        // Simultaneous push+pop at occupancy 1 across pointer wrap
        id_ready = 1'b0; if_valid = 1'b1; if_in = {16'hA000, 8'h10};
        tick();
        check("pp_prime_pc", 32'(id_pc), 32'h10);
        id_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if_in = {16'hA000 | 16'(i), 8'(8'h10 + i)};
            tick();
            check("pp_occ", 32'(occupancy), 32'd1);
            check("pp_pc", 32'(id_pc), 32'(8'h10 + i));
            check("pp_instr", 32'(id_instr), 32'(16'hA000 | 16'(i)));
        end
        if_valid = 1'b0;
        tick();
        check("pp_drain_occ", 32'(occupancy), 32'd0);

        // Flush at occupancy 2 with an incoming bundle and a pop request
        id_ready = 1'b0; if_valid = 1'b1; if_in = {16'h5555, 8'h05};
        tick();
        if_in = {16'h6666, 8'h06};
        tick();
        check("preflush_occ", 32'(occupancy), 32'd2);
        if_in = {16'h7777, 8'h07}; id_ready = 1'b1; flush = 1'b1;
        tick();
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_valid", 32'(id_valid), 32'd0);
        check("flush_ready", 32'(if_ready), 32'd1);
        check("flush_stall", 32'(stall_cnt), 32'd1);
        flush = 1'b0; id_ready = 1'b0; if_in = {16'h4444, 8'h04};
        tick();
        check("postflush_valid", 32'(id_valid), 32'd1);
        check("postflush_pc", 32'(id_pc), 32'h04);
        check("postflush_occ", 32'(occupancy), 32'd1);
        if_valid = 1'b0; id_ready = 1'b1;
        tick();
        check("postflush_drain", 32'(id_valid), 32'd0);

        // Asynchronous reset between edges at occupancy 2
        id_ready = 1'b0; if_valid = 1'b1; if_in = {16'h1111, 8'h21};
        tick();
        if_in = {16'h2222, 8'h22};
        tick();
        if_valid = 1'b0;
        check("prearst_occ", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(id_valid), 32'd0);
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_stall", 32'(stall_cnt), 32'd0);
        check("arst_ready", 32'(if_ready), 32'd1);
        check("arst_pc", 32'(id_pc), 32'd0);
        #3;
        rst_n = 1'b1;

        // Long back-pressure: stall counter saturates
        if_valid = 1'b1; if_in = {16'h9999, 8'h30};
        tick();
        tick();
        check("sat_full_ready", 32'(if_ready), 32'd0);
        check("sat_start", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 300; i++) tick();
        check("sat_value", 32'(stall_cnt), 32'd255);
        tick();
        tick();
        check("sat_hold", 32'(stall_cnt), 32'd255);
        check("sat_occ", 32'(occupancy), 32'd2);
        check("sat_head", 32'(id_pc), 32'h30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
